// File: rtl/chino_sopc_bus_pkg.sv
// +--------------------------------------------------------------------+
// | chino_sopc_bus_pkg : shared FSM encodings and bus defaults           |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

package chino_sopc_bus_pkg;

  localparam int DEF_SEL_BITS = 4;
  localparam int DEF_TIMEOUT  = 15;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_REQ  = 2'd1,
    BUS_RESP = 2'd2
  } bus_state_t;

endpackage

`default_nettype wire

// File: rtl/chino_bus_decode.sv
// +--------------------------------------------------------------------+
// | chino_bus_decode : top address bits -> slave index and map hit       |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module chino_bus_decode
  import chino_sopc_bus_pkg::*;
#(
  parameter int SEL_BITS = DEF_SEL_BITS,
  parameter int NUM_SLV  = 4
) (
  input  logic [SEL_BITS-1:0] i_addr_top,
  output logic [SEL_BITS-1:0] o_idx,
  output logic                o_hit
);

  // One extra bit so NUM_SLV == 2**SEL_BITS still compares correctly
  localparam logic [SEL_BITS:0] C_NUM_SLV = (SEL_BITS+1)'(NUM_SLV);

  assign o_idx = i_addr_top;
  assign o_hit = ({1'b0, i_addr_top} < C_NUM_SLV);

endmodule

`default_nettype wire

// File: rtl/chino_sopc_bus.sv
// +--------------------------------------------------------------------+
// | chino_sopc_bus : core data port to NUM_SLV slaves, ack/timeout FSM   |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module chino_sopc_bus
  import chino_sopc_bus_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_SLV  = 4,
  parameter int SEL_BITS = DEF_SEL_BITS,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m_ce_i,
  input  logic                    m_we_i,
  input  logic [ADDR_W-1:0]       m_addr_i,
  input  logic [DATA_W/8-1:0]     m_sel_i,
  input  logic [DATA_W-1:0]       m_data_i,
  output logic [DATA_W-1:0]       m_data_o,
  output logic                    m_stall_o,
  output logic                    m_err_o,
  output logic [NUM_SLV-1:0]      s_ce_o,
  output logic                    s_we_o,
  output logic [ADDR_W-1:0]       s_addr_o,
  output logic [DATA_W/8-1:0]     s_sel_o,
  output logic [DATA_W-1:0]       s_data_o,
  input  logic [NUM_SLV*DATA_W-1:0] s_data_i,
  input  logic [NUM_SLV-1:0]      s_ack_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

  bus_state_t              r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [SEL_BITS-1:0]     r_idx;
  logic                    r_we;
  logic [ADDR_W-1:0]       r_addr;
  logic [DATA_W/8-1:0]     r_sel;
  logic [DATA_W-1:0]       r_wdata;
  logic [DATA_W-1:0]       r_rdata;
  logic                    r_err;
  logic [NUM_SLV-1:0]      r_s_ce;

  logic [SEL_BITS-1:0]     w_idx;
  logic                    w_hit;
  logic [NUM_SLV-1:0]      w_onehot;
  logic                    w_ack;
  logic [DATA_W-1:0]       w_rdata;

  chino_bus_decode #(
    .SEL_BITS (SEL_BITS),
    .NUM_SLV  (NUM_SLV)
  ) u_decode (
    .i_addr_top (m_addr_i[ADDR_W-1 -: SEL_BITS]),
    .o_idx      (w_idx),
    .o_hit      (w_hit)
  );

  always_comb begin
    w_onehot = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      w_onehot[k] = (w_idx == SEL_BITS'(k));
    end
  end

  // Only the latched slave's ack and data are visible to the FSM
  always_comb begin
    w_ack   = 1'b0;
    w_rdata = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (r_idx == SEL_BITS'(k)) begin
        w_ack   = s_ack_i[k];
        w_rdata = s_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= BUS_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_sel   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_s_ce  <= '0;
    end else begin
      case (r_state)
        BUS_IDLE: begin
          if (m_ce_i) begin
            r_idx   <= w_idx;
            r_we    <= m_we_i;
            r_addr  <= m_addr_i;
            r_sel   <= m_sel_i;
            r_wdata <= m_data_i;
            r_cnt   <= '0;
            if (w_hit) begin
              r_state <= BUS_REQ;
              r_s_ce  <= w_onehot;
            end else begin
              r_state <= BUS_RESP;
              r_rdata <= '0;
              r_err   <= 1'b1;
            end
          end
        end
        BUS_REQ: begin
          // Ack takes priority over a coincident timeout
          if (w_ack) begin
            r_state <= BUS_RESP;
            r_s_ce  <= '0;
            r_rdata <= r_we ? '0 : w_rdata;
            r_err   <= 1'b0;
          end else if (r_cnt == C_TIMEOUT) begin
            r_state <= BUS_RESP;
            r_s_ce  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        BUS_RESP: begin
          r_state <= BUS_IDLE;
          r_err   <= 1'b0;
        end
        default: begin
          r_state <= BUS_IDLE;
          r_s_ce  <= '0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign m_stall_o = ((r_state == BUS_IDLE) && m_ce_i) || (r_state == BUS_REQ);
  assign m_data_o  = r_rdata;
  assign m_err_o   = r_err;
  assign s_ce_o    = r_s_ce;
  assign s_we_o    = r_we;
  assign s_addr_o  = r_addr;
  assign s_sel_o   = r_sel;
  assign s_data_o  = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_chino_sopc_bus.sv
// +--------------------------------------------------------------------+
// | tb_chino_sopc_bus : randomized bench against a transaction model     |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_chino_sopc_bus;

  localparam int NSLV = 4;
  localparam int TMO  = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              m_ce_i;
  logic              m_we_i;
  logic [31:0]       m_addr_i;
  logic [3:0]        m_sel_i;
  logic [31:0]       m_data_i;
  logic [31:0]       m_data_o;
  logic              m_stall_o;
  logic              m_err_o;
  logic [NSLV-1:0]   s_ce_o;
  logic              s_we_o;
  logic [31:0]       s_addr_o;
  logic [3:0]        s_sel_o;
  logic [31:0]       s_data_o;
  logic [NSLV*32-1:0] s_data_i;
  logic [NSLV-1:0]   s_ack_i;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] slave_mem [NSLV];
  logic [31:0] last_data;

  chino_sopc_bus u_dut (
    .clk       (clk),
    .rst       (rst),
    .m_ce_i    (m_ce_i),
    .m_we_i    (m_we_i),
    .m_addr_i  (m_addr_i),
    .m_sel_i   (m_sel_i),
    .m_data_i  (m_data_i),
    .m_data_o  (m_data_o),
    .m_stall_o (m_stall_o),
    .m_err_o   (m_err_o),
    .s_ce_o    (s_ce_o),
    .s_we_o    (s_we_o),
    .s_addr_o  (s_addr_o),
    .s_sel_o   (s_sel_o),
    .s_data_o  (s_data_o),
    .s_data_i  (s_data_i),
    .s_ack_i   (s_ack_i)
  );

  always #5 clk = ~clk;

  task automatic load_slaves();
    for (int k = 0; k < NSLV; k++) begin
      slave_mem[k] = $urandom | 32'h1;
      s_data_i[k*32 +: 32] = slave_mem[k];
    end
  endtask

  // One complete transaction from the core's view. ack_at is the REQ cycle
  // (1-based) in which the addressed slave acks; 0 means never.
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                         input logic [31:0] wdata, input int ack_at, input bit spur,
                         input string name);
    int          idx;
    bit          hit;
    int          resp;
    logic        e_err;
    logic [31:0] e_dat;
    logic [3:0]  e_ce;
    logic [3:0]  ack;
    idx = int'(addr[31:28]);
    hit = (idx < NSLV);
    if (!hit) begin
      resp = 1; e_err = 1'b1; e_dat = 32'h0;
    end else if (ack_at >= 1 && ack_at <= TMO + 1) begin
      resp = ack_at + 1; e_err = 1'b0; e_dat = we ? 32'h0 : slave_mem[idx];
    end else begin
      resp = TMO + 2; e_err = 1'b1; e_dat = 32'h0;
    end
    for (int c = 0; c <= resp; c++) begin
      if (c == 0) begin
        m_ce_i = 1'b1; m_we_i = we; m_addr_i = addr; m_sel_i = sel; m_data_i = wdata;
      end else if (c < resp) begin
        m_ce_i = 1'b1; m_we_i = 1'($urandom); m_addr_i = $urandom;
        m_sel_i = 4'($urandom); m_data_i = $urandom;
      end else begin
        m_ce_i = 1'b0;
      end
      ack = spur ? 4'($urandom) : 4'h0;
      if (hit && c >= 1 && c < resp) ack[idx] = (c == ack_at);
      s_ack_i = ack;
      @(negedge clk);
      e_ce = (hit && c >= 1 && c < resp) ? 4'(1 << idx) : 4'h0;
      checks++;
      if (m_stall_o !== (c < resp)) begin
        errors++;
        $display("FAIL %s stall c=%0d got %b exp %b", name, c, m_stall_o, (c < resp));
      end
      checks++;
      if (s_ce_o !== e_ce) begin
        errors++;
        $display("FAIL %s s_ce c=%0d got %b exp %b", name, c, s_ce_o, e_ce);
      end
      checks++;
      if (m_err_o !== ((c == resp) ? e_err : 1'b0)) begin
        errors++;
        $display("FAIL %s err c=%0d got %b exp %b", name, c, m_err_o, (c == resp) ? e_err : 1'b0);
      end
      checks++;
      if (m_data_o !== ((c == resp) ? e_dat : last_data)) begin
        errors++;
        $display("FAIL %s data c=%0d got %h exp %h", name, c, m_data_o,
                 (c == resp) ? e_dat : last_data);
      end
      if (hit && c >= 1 && c < resp) begin
        checks++;
        if ({s_we_o, s_addr_o, s_sel_o, s_data_o} !== {we, addr, sel, wdata}) begin
          errors++;
          $display("FAIL %s shared c=%0d got %b/%h/%b/%h exp %b/%h/%b/%h", name, c,
                   s_we_o, s_addr_o, s_sel_o, s_data_o, we, addr, sel, wdata);
        end
      end
      if (c == resp) last_data = e_dat;
      @(posedge clk);
      #1;
    end
    s_ack_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; m_ce_i = 1'b0; m_we_i = 1'b0; m_addr_i = '0; m_sel_i = '0;
    m_data_i = '0; s_ack_i = '0; s_data_i = '0; last_data = '0;
    load_slaves();
    #3;
    checks++;
    if ({m_data_o, m_stall_o, m_err_o, s_ce_o, s_we_o, s_addr_o, s_sel_o, s_data_o} !== '0) begin
      errors++;
      $display("FAIL reset outputs got %h/%b/%b/%b/%b/%h/%b/%h exp all zero", m_data_o,
               m_stall_o, m_err_o, s_ce_o, s_we_o, s_addr_o, s_sel_o, s_data_o);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_read_basic();
    slave_mem[1] = 32'hDEADBEEF;
    s_data_i[32 +: 32] = 32'hDEADBEEF;
    run_txn(32'h1000_0010, 1'b0, 4'hF, 32'h0, 1, 1'b0, "read_basic");
  endtask

  task automatic test_write_delay();
    run_txn(32'h0000_0040, 1'b1, 4'b0011, 32'h1234_5678, 3, 1'b0, "write_delay");
  endtask

  task automatic test_unmapped();
    run_txn(32'hF000_0000, 1'b0, 4'hF, 32'h0, 1, 1'b1, "unmapped");
    run_txn(32'h4000_0000, 1'b1, 4'h0, 32'hFFFF_FFFF, 1, 1'b0, "unmapped_edge");
  endtask

  task automatic test_timeout();
    run_txn(32'h2000_0008, 1'b0, 4'hF, 32'h0, 0, 1'b0, "timeout");
    run_txn(32'h3000_000C, 1'b0, 4'hF, 32'h0, TMO + 1, 1'b0, "ack_last_cycle");
  endtask

  task automatic test_spurious();
    // Acks while idle must not start anything
    m_ce_i = 1'b0;
    s_ack_i = 4'hF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({m_stall_o, m_err_o, s_ce_o} !== 6'b0 || m_data_o !== last_data) begin
        errors++;
        $display("FAIL idle_ack got stall=%b err=%b ce=%b data=%h exp 0/0/0/%h",
                 m_stall_o, m_err_o, s_ce_o, m_data_o, last_data);
      end
      @(posedge clk); #1;
    end
    s_ack_i = '0;
    run_txn(32'h1000_0020, 1'b0, 4'hF, 32'h0, 5, 1'b1, "spurious");
  endtask

  task automatic test_reset_mid();
    run_txn(32'h3000_0000, 1'b0, 4'hF, 32'h0, 2, 1'b0, "pre_reset");
    m_ce_i = 1'b1; m_we_i = 1'b1; m_addr_i = 32'h1000_0004; m_sel_i = 4'hF; m_data_i = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b0;
    m_ce_i = 1'b0;
    #1;
    checks++;
    if ({m_data_o, m_stall_o, m_err_o, s_ce_o, s_we_o, s_addr_o, s_sel_o, s_data_o} !== '0) begin
      errors++;
      $display("FAIL reset_mid outputs got %h/%b/%b/%b/%b/%h/%b/%h exp all zero", m_data_o,
               m_stall_o, m_err_o, s_ce_o, s_we_o, s_addr_o, s_sel_o, s_data_o);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    last_data = '0;
    load_slaves();
    run_txn(32'h1000_0004, 1'b0, 4'hF, 32'h0, 2, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      logic [31:0] addr;
      int          r;
      int          ack_at;
      addr = {4'($urandom_range(0, 5)), 28'($urandom)};
      r = $urandom_range(0, 9);
      if (r == 0)      ack_at = 0;
      else if (r == 1) ack_at = $urandom_range(TMO, TMO + 1);
      else             ack_at = $urandom_range(1, 6);
      if (t % 7 == 0) load_slaves();
      run_txn(addr, 1'($urandom), 4'($urandom), $urandom, ack_at, 1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_delay();
    test_unmapped();
    test_timeout();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/chino_sopc_bus.md
# chino_sopc_bus

Parametrised data-side interconnect between the `chino` core's data port and `NUM_SLV` memory-mapped slaves (data RAM, peripherals). It replaces the direct core-to-`data_ram` wiring of the single-slave system. It decodes the top address bits, holds the request in registers, and waits for a per-slave acknowledge. It stalls the core while waiting and reports an error on an unmapped address or an acknowledge timeout.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `DATA_W/8` byte selects
- `NUM_SLV`, 4, number of slaves, 1..16
- `SEL_BITS`, 4, top address bits used as slave index
- `TIMEOUT`, 15, maximum wait cycles for an acknowledge, ≥1

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `m_ce_i`  in  1  core request
- `m_we_i`  in  1  1 = write
- `m_addr_i`  in  ADDR_W  byte address
- `m_sel_i`  in  DATA_W/8  byte enables
- `m_data_i`  in  DATA_W  write data
- `m_data_o`  out  DATA_W  read data, valid in the RESP cycle
- `m_stall_o`  out  1  core must hold its request
- `m_err_o`  out  1  error pulse, RESP cycle only
- `s_ce_o`  out  NUM_SLV  one-hot slave select
- `s_we_o`  out  1  shared write enable
- `s_addr_o`  out  ADDR_W  shared address
- `s_sel_o`  out  DATA_W/8  shared byte enables
- `s_data_o`  out  DATA_W  shared write data
- `s_data_i`  in  NUM_SLV*DATA_W  read data, slave k at `[k*DATA_W +: DATA_W]`
- `s_ack_i`  in  NUM_SLV  per-slave acknowledge

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE → REQ when `m_ce_i`=1.
  - Latch we/addr/sel/data into request registers.
  - `idx = m_addr_i[ADDR_W-1 -: SEL_BITS]`.
  - If `idx ≥ NUM_SLV`, go IDLE → RESP directly with the error flag set.
- REQ:
  - `s_ce_o[idx]`=1; all other `s_ce_o` bits are 0.
  - `s_we_o`/`s_addr_o`/`s_sel_o`/`s_data_o` come from the request registers and stay stable for the whole REQ state.
- REQ → RESP on `s_ack_i[idx]`=1.
  - Capture read data into `m_data_o` (writes capture 0).
  - `m_err_o`=0.
- REQ → RESP when the wait counter equals `TIMEOUT` with no ack.
  - `m_data_o`=0, error flag set.
  - If the ack and the timeout occur in the same cycle, the ack wins.
- Wait counter: width `$clog2(TIMEOUT+1)`. Cleared on REQ entry, +1 per REQ cycle. It never wraps.
- RESP → IDLE unconditionally after one cycle.
  - `m_data_o` holds its value until the next RESP.
  - `m_err_o` is 1 only during RESP.
- `m_stall_o = (IDLE & m_ce_i) | REQ`. It is 0 in RESP, when the core advances.
- `s_ack_i` bits of non-selected slaves and acks arriving in IDLE/RESP are ignored.
- A `m_ce_i` still high in the cycle after RESP (IDLE) starts a new transaction.
- Unmapped error responses return data 0.
- `m_sel_i`=0 is forwarded unchanged; the bus does not filter it.

## Timing
- Reset (`rst`=0, asynchronous):
  - State goes to IDLE; counter and request registers clear.
  - All outputs are 0: `m_data_o`, `m_stall_o` (with `m_ce_i`=0), `m_err_o`, `s_ce_o`, `s_we_o`, `s_addr_o`, `s_sel_o`, `s_data_o`.
  - Reset mid-REQ abandons the transaction; `s_ce_o` drops immediately.
- Cycle 0: IDLE, `m_ce_i`=1, stall=1.
  - Cycle 1: REQ, `s_ce_o` high.
  - Ack in cycle n≥1 → RESP in cycle n+1.
  - Best case 3 cycles, 2 of them stalled.
- Timeout: REQ lasts `TIMEOUT+1` cycles, then RESP.
- Unmapped address: RESP in cycle 1, 1 stall cycle.
- Slaves must keep ack combinational or registered; the bus samples ack on the rising edge.

## Structure
- Shared package/defines (alongside `defines.v`):
  - FSM state encodings `BUS_IDLE`/`BUS_REQ`/`BUS_RESP`.
  - Default `SEL_BITS`/`TIMEOUT` constants.
- One sub-module, `chino_bus_decode`: combinational address → `{idx, hit}`.
- The FSM, counter and muxes live in `chino_sopc_bus`.

## Test plan
- Read slave 1 (`addr=0x1000_0010`), ack in first REQ cycle, data `0xDEADBEEF` → `s_ce_o=4'b0010`, RESP in cycle 2, `m_data_o=0xDEADBEEF`, stall high for cycles 0–1, `m_err_o`=0.
- Write slave 0 (`sel=4'b0011`, data `0x1234_5678`), ack after 3 REQ cycles → shared signals stable throughout REQ, RESP in cycle 4, `m_data_o=0`.
- Unmapped address `0xF000_0000` with `NUM_SLV=4` → `s_ce_o` never asserted, RESP in cycle 1 with `m_err_o`=1, `m_data_o=0`.
- No ack, `TIMEOUT=15` → REQ for 16 cycles, then `m_err_o`=1. Variant: ack in the final REQ cycle → `m_err_o`=0, data returned.
- Spurious `s_ack_i[2]` while addressing slave 1, and ack in IDLE → ignored, the transaction still waits for `s_ack_i[1]`.
- `rst` low in the 2nd REQ cycle → all outputs 0 asynchronously. After release, a new read completes normally with no stale data.
